// File: rtl/key_event.sv
// key_event: turns a debounced key level into press/release/long-press/repeat pulses on a 1 ms tick.
// Auto-repeat in LONG is built only when KEY_EVENT_REPEAT_EN is defined.
module key_event #(
   parameter int CLK_DIV   = 50000,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [15:0] LONG_MAX = 16'(LONG_MS - 1);
   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
   state_t state;
   logic key_d, tick, rise, fall;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [15:0] ms_cnt;
   assign rise = key & ~key_d;
   assign fall = ~key & key_d;
   assign div_nxt = div_cnt == DIV_MAX ? '0 : div_cnt + DW'(1);
`ifndef KEY_EVENT_REPEAT_EN
   assign repeat_pulse = 1'b0;
`endif
   // tick is registered but lines up with div_cnt == CLK_DIV-1
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_d         <= 1'b0;
         div_cnt       <= '0;
         tick          <= 1'b0;
         ms_cnt        <= '0;
         state         <= IDLE;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         held          <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
         repeat_pulse  <= 1'b0;
`endif
      end else begin
         key_d         <= key;
         div_cnt       <= div_nxt;
         tick          <= div_nxt == DIV_MAX;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
         repeat_pulse  <= 1'b0;
`endif
         case (state)
            IDLE: if (rise) begin
               press  <= 1'b1;
               ms_cnt <= '0;
               state  <= PRESSED;
               held   <= 1'b1;
            end
            PRESSED: if (fall) begin
               release_pulse <= 1'b1;
               ms_cnt        <= '0;
               state         <= IDLE;
               held          <= 1'b0;
            end else if (tick && ms_cnt == LONG_MAX) begin
               long_press <= 1'b1;
               ms_cnt     <= '0;
               state      <= LONG;
            end else if (tick) begin
               ms_cnt <= ms_cnt + 16'd1;
            end
            LONG: if (fall) begin
               release_pulse <= 1'b1;
               ms_cnt        <= '0;
               state         <= IDLE;
               held          <= 1'b0;
            end
`ifdef KEY_EVENT_REPEAT_EN
            else if (tick && ms_cnt == 16'(REPEAT_MS - 1)) begin
               repeat_pulse <= 1'b1;
               ms_cnt       <= '0;
            end else if (tick) begin
               ms_cnt <= ms_cnt + 16'd1;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule
